// File: rtl/stream_framer.sv
// rtl/stream_framer.sv - marks a raw pixel stream with sop/eop/sof/eof and counts frames
// Optional STREAM_FRAMER_RESYNC_EN: a frame_start_i pulse mid-frame restarts the frame at pixel (0,0).
module stream_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  frame_start_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [FCNT_WIDTH-1:0] frame_cnt_o
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE} state_t;

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dv_q, dv_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  sof_q, sof_d;
  logic                  eof_q, eof_d;
  logic                  busy_q, busy_d;

  // pos_* is the coordinate the current beat is emitted at; starts and resyncs force (0,0)
  logic                  fire;
  logic                  last_px;
  logic [COL_W-1:0]      pos_col;
  logic [ROW_W-1:0]      pos_row;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    fcnt_d  = fcnt_q;
    err_d   = err_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    fire    = 1'b0;
    pos_col = col_q;
    pos_row = row_q;
    last_px = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          if (valid_i) begin
            fire    = 1'b1;
            pos_col = '0;
            pos_row = '0;
          end else begin
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (valid_i) begin
          fire    = 1'b1;
          pos_col = '0;
          pos_row = '0;
        end
      end
      S_ACTIVE: begin
        if (frame_start_i && !(valid_i && row_q == ROW_LAST && col_q == COL_LAST)) begin
          err_d = 1'b1;
`ifdef STREAM_FRAMER_RESYNC_EN
          pos_col = '0;
          pos_row = '0;
          col_d   = '0;
          row_d   = '0;
          if (!valid_i) state_d = S_ARMED;
`endif
        end
        fire = valid_i;
      end
      default: state_d = S_IDLE;
    endcase

    if (fire) begin
      last_px = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
      dv_d    = 1'b1;
      data_d  = data_i;
      sop_d   = (pos_col == '0);
      eop_d   = (pos_col == COL_LAST);
      sof_d   = (pos_col == '0) && (pos_row == '0);
      eof_d   = last_px;
      if (last_px) begin
        col_d   = '0;
        row_d   = '0;
        fcnt_d  = fcnt_q + FCNT_WIDTH'(1);
        state_d = frame_start_i ? S_ARMED : S_IDLE;
      end else begin
        state_d = S_ACTIVE;
        if (pos_col == COL_LAST) begin
          col_d = '0;
          row_d = pos_row + ROW_W'(1);
        end else begin
          col_d = pos_col + COL_W'(1);
          row_d = pos_row;
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = dv_q;
  assign sop_o        = sop_q;
  assign eop_o        = eop_q;
  assign sof_o        = sof_q;
  assign eof_o        = eof_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
  assign frame_cnt_o  = fcnt_q;

endmodule

// File: tb/tb_stream_framer.sv
// tb/tb_stream_framer.sv - directed bench for stream_framer (4x2 frames) with a pixel-index reference model
module tb_stream_framer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       frame_start_i = 1'b0;
  logic [7:0] data_o;
  logic       data_valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, err_o;
  logic [15:0] frame_cnt_o;

  int checks = 0;
  int failures = 0;

  stream_framer #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FCNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
    .frame_start_i(frame_start_i), .data_o(data_o), .data_valid_o(data_valid_o),
    .sop_o(sop_o), .eop_o(eop_o), .sof_o(sof_o), .eof_o(eof_o), .busy_o(busy_o),
    .err_o(err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference: frame position tracked as a linear pixel index 0..N-1
  logic       m_in_frame = 0, m_armed = 0, m_err = 0;
  int         m_idx = 0;
  logic [15:0] m_frames = '0;
  logic [7:0] e_data = '0;
  logic       e_dv = 0, e_sop = 0, e_eop = 0, e_sof = 0, e_eof = 0, e_busy = 0;

  always @(posedge clk) begin
    logic emit;
    emit = 0;
    e_dv = 0; e_sop = 0; e_eop = 0; e_sof = 0; e_eof = 0;
    if (reset) begin
      m_in_frame = 0; m_armed = 0; m_err = 0; m_idx = 0; m_frames = '0; e_data = '0;
    end else begin
      if (!m_in_frame && !m_armed) begin
        if (frame_start_i) begin
          if (valid_i) begin emit = 1; m_idx = 0; end
          else m_armed = 1;
        end
      end else if (m_armed) begin
        if (valid_i) begin emit = 1; m_idx = 0; m_armed = 0; end
      end else begin
        if (frame_start_i && !(valid_i && m_idx == N - 1)) begin
          m_err = 1;
`ifdef STREAM_FRAMER_RESYNC_EN
          m_idx = 0;
          if (!valid_i) begin m_in_frame = 0; m_armed = 1; end
`endif
        end
        if (valid_i && m_in_frame) emit = 1;
      end
      if (emit) begin
        e_data = data_i;
        e_dv   = 1;
        e_sop  = (m_idx % W == 0);
        e_eop  = (m_idx % W == W - 1);
        e_sof  = (m_idx == 0);
        e_eof  = (m_idx == N - 1);
        if (e_eof) begin
          m_frames   = m_frames + 16'd1;
          m_in_frame = 0;
          m_armed    = frame_start_i;
          m_idx      = 0;
        end else begin
          m_in_frame = 1;
          m_idx      = m_idx + 1;
        end
      end
    end
    e_busy = m_in_frame || m_armed;
  end

  logic [11:0] beats[$];

  always @(negedge clk) begin
    checks++;
    if ({data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, err_o, frame_cnt_o} !==
        {e_data, e_dv, e_sop, e_eop, e_sof, e_eof, e_busy, m_err, m_frames}) begin
      failures++;
      $display("FAIL cycle_model t=%0t got d=%h v=%b sop=%b eop=%b sof=%b eof=%b busy=%b err=%b fc=%0d want d=%h v=%b sop=%b eop=%b sof=%b eof=%b busy=%b err=%b fc=%0d",
               $time, data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, err_o, frame_cnt_o,
               e_data, e_dv, e_sop, e_eop, e_sof, e_eof, e_busy, m_err, m_frames);
    end
    if (data_valid_o) beats.push_back({data_o, sop_o, eop_o, sof_o, eof_o});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic v, input logic [7:0] d);
    frame_start_i = s;
    valid_i       = v;
    data_i        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    reset = 0;
    beats.delete();
  endtask

  task automatic beat_at(input int i, input logic [11:0] exp, input string name);
    if (beats.size() > i) chk(name, {52'd0, beats[i]}, {52'd0, exp});
    else chk({name, "_missing"}, 64'(beats.size()), 64'(i + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk("reset_outputs", {data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, err_o, frame_cnt_o}, 64'd0);

    // Nominal frame
    cyc(1, 0, 8'h00);
    for (int i = 0; i < N; i++) cyc(0, 1, 8'(8'h10 + i));
    cyc(0, 0, 8'h00);
    beat_at(0, {8'h10, 4'b1010}, "nom_px0");
    beat_at(3, {8'h13, 4'b0100}, "nom_px3");
    beat_at(4, {8'h14, 4'b1000}, "nom_px4");
    beat_at(7, {8'h17, 4'b0101}, "nom_px7");
    chk("nom_fcnt", 64'(frame_cnt_o), 64'd1);
    chk("nom_busy", 64'(busy_o), 64'd0);

    // Beats before any frame start are dropped
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'(8'h50 + i));
    cyc(0, 0, 8'h00);
    chk("prearm_dropped", 64'(beats.size()), 64'd0);
    cyc(1, 1, 8'hAA);
    cyc(0, 0, 8'h00);
    beat_at(0, {8'hAA, 4'b1010}, "prearm_aa");

    // Gapped stream
    do_reset();
    cyc(1, 0, 8'h00);
    for (int i = 0; i < 2 * N; i++) cyc(0, (i % 2) == 0, 8'(8'h20 + i / 2));
    cyc(0, 0, 8'h00);
    beat_at(0, {8'h20, 4'b1010}, "gap_px0");
    beat_at(3, {8'h23, 4'b0100}, "gap_px3");
    beat_at(4, {8'h24, 4'b1000}, "gap_px4");
    beat_at(7, {8'h27, 4'b0101}, "gap_px7");

    // Back-to-back frames, next start on the eof beat
    do_reset();
    cyc(1, 0, 8'h00);
    for (int i = 0; i < N; i++) cyc(i == N - 1, 1, 8'(8'h30 + i));
    for (int i = 0; i < N; i++) cyc(0, 1, 8'(8'h40 + i));
    cyc(0, 0, 8'h00);
    beat_at(8, {8'h40, 4'b1010}, "b2b_sof");
    beat_at(15, {8'h47, 4'b0101}, "b2b_eof");
    chk("b2b_fcnt", 64'(frame_cnt_o), 64'd2);
    chk("b2b_err", 64'(err_o), 64'd0);

    // Frame start at pixel 5 with valid high
    do_reset();
    cyc(1, 0, 8'h00);
    for (int i = 0; i < N; i++) cyc(i == 5, 1, 8'(8'h60 + i));
    cyc(0, 0, 8'h00);
    chk("mid_err", 64'(err_o), 64'd1);
`ifdef STREAM_FRAMER_RESYNC_EN
    beat_at(5, {8'h65, 4'b1010}, "mid_resync_sof");
    chk("mid_fcnt_before", 64'(frame_cnt_o), 64'd0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'h70 + i));
    cyc(0, 0, 8'h00);
    beat_at(12, {8'h74, 4'b0101}, "mid_resync_eof");
    chk("mid_fcnt_after", 64'(frame_cnt_o), 64'd1);
`else
    beat_at(5, {8'h65, 4'b0000}, "mid_px5");
    beat_at(7, {8'h67, 4'b0101}, "mid_eof");
    chk("mid_fcnt", 64'(frame_cnt_o), 64'd1);
`endif

    // Reset asserted while pixel 3 is in flight
    do_reset();
    cyc(1, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'(8'h80 + i));
    reset = 1;
    cyc(0, 1, 8'h84);
    chk("rst_mid_outputs", {data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, err_o, frame_cnt_o}, 64'd0);
    reset = 0;
    cyc(0, 0, 8'h00);
    beats.delete();
    cyc(1, 0, 8'h00);
    for (int i = 0; i < N; i++) cyc(0, 1, 8'(8'h90 + i));
    cyc(0, 0, 8'h00);
    beat_at(0, {8'h90, 4'b1010}, "rst_px0");
    beat_at(7, {8'h97, 4'b0101}, "rst_px7");
    chk("rst_fcnt", 64'(frame_cnt_o), 64'd1);

    cyc(0, 0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
